// File: rtl/contador_ocupacion.sv
// rtl/contador_ocupacion.sv - saturating occupancy counter with binary and BCD outputs
// Entry/exit pulses from the direction sensor move a count kept in lockstep in binary and two BCD digits.
module contador_ocupacion #(
  parameter int MAX_COUNT = 25,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x0,
  input  logic             y0,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units,
  output logic             empty,
  output logic             full,
  output logic             err_over,
  output logic             err_under,
  output logic             alarm
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_NORMAL = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] L_MAX     = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] L_MAX_M1  = CNT_W'(MAX_COUNT - 1);
  localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
  localparam logic             L_MAX_ONE = (MAX_COUNT == 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_tens;
  logic [3:0]       r_units;
  logic             r_empty;
  logic             r_full;
  logic             r_err_over;
  logic             r_err_under;
  logic             r_alarm;

  // BCD steps carry/borrow between digits so no divider is needed
  logic [3:0] w_tens_inc, w_units_inc, w_tens_dec, w_units_dec;

  always_comb begin
    w_units_inc = (r_units == 4'd9) ? 4'd0 : r_units + 4'd1;
    w_tens_inc  = (r_units == 4'd9) ? r_tens + 4'd1 : r_tens;
    w_units_dec = (r_units == 4'd0) ? 4'd9 : r_units - 4'd1;
    w_tens_dec  = (r_units == 4'd0) ? r_tens - 4'd1 : r_tens;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_count     <= '0;
      r_tens      <= 4'd0;
      r_units     <= 4'd0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_err_over  <= 1'b0;
      r_err_under <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_err_over  <= 1'b0;
      r_err_under <= 1'b0;
      if (clr) begin
        r_state <= ST_EMPTY;
        r_count <= '0;
        r_tens  <= 4'd0;
        r_units <= 4'd0;
        r_empty <= 1'b1;
        r_full  <= 1'b0;
        r_alarm <= 1'b0;
      end else if (!(x0 && y0)) begin
        case (r_state)
          ST_EMPTY: begin
            if (x0) begin
              r_count <= r_count + L_ONE;
              r_tens  <= w_tens_inc;
              r_units <= w_units_inc;
              r_state <= L_MAX_ONE ? ST_FULL : ST_NORMAL;
              r_empty <= 1'b0;
              r_full  <= L_MAX_ONE;
            end else if (y0) begin
              r_err_under <= 1'b1;
              r_alarm     <= 1'b1;
            end
          end
          ST_NORMAL: begin
            if (x0) begin
              r_count <= r_count + L_ONE;
              r_tens  <= w_tens_inc;
              r_units <= w_units_inc;
              if (r_count == L_MAX_M1) begin
                r_state <= ST_FULL;
                r_full  <= 1'b1;
              end
            end else if (y0) begin
              r_count <= r_count - L_ONE;
              r_tens  <= w_tens_dec;
              r_units <= w_units_dec;
              if (r_count == L_ONE) begin
                r_state <= ST_EMPTY;
                r_empty <= 1'b1;
              end
            end
          end
          ST_FULL: begin
            if (x0) begin
              r_err_over <= 1'b1;
              r_alarm    <= 1'b1;
            end else if (y0) begin
              r_count <= r_count - L_ONE;
              r_tens  <= w_tens_dec;
              r_units <= w_units_dec;
              r_full  <= 1'b0;
              // With a capacity of one, leaving full means leaving empty-side too
              if (r_count == L_ONE) begin
                r_state <= ST_EMPTY;
                r_empty <= 1'b1;
              end else begin
                r_state <= ST_NORMAL;
              end
            end
          end
          default: begin
            r_state <= ST_EMPTY;
            r_count <= '0;
            r_tens  <= 4'd0;
            r_units <= 4'd0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count     = r_count;
  assign bcd_tens  = r_tens;
  assign bcd_units = r_units;
  assign empty     = r_empty;
  assign full      = r_full;
  assign err_over  = r_err_over;
  assign err_under = r_err_under;
  assign alarm     = r_alarm;

  logic w_unused_max;
  assign w_unused_max = ^L_MAX;

endmodule

// File: tb/tb_contador_ocupacion.sv
// tb/tb_contador_ocupacion.sv - directed self-checking bench for contador_ocupacion
module tb_contador_ocupacion;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x0 = 1'b0;
  logic       y0 = 1'b0;
  logic       clr = 1'b0;
  logic [6:0] count;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
  logic       empty;
  logic       full;
  logic       err_over;
  logic       err_under;
  logic       alarm;

  int errors = 0;
  int checks = 0;

  contador_ocupacion #(.MAX_COUNT(25), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .x0(x0), .y0(y0), .clr(clr),
    .count(count), .bcd_tens(bcd_tens), .bcd_units(bcd_units),
    .empty(empty), .full(full), .err_over(err_over), .err_under(err_under),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Drives one-cycle pulses; returns at the negedge after the sampling posedge
  task automatic pulse(input logic px, input logic py, input logic pc);
    @(negedge clk);
    x0 = px; y0 = py; clr = pc;
    @(negedge clk);
    x0 = 1'b0; y0 = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (count !== 7'd0 || bcd_tens !== 4'd0 || bcd_units !== 4'd0) begin
      errors++;
      $display("FAIL reset_count: count=%0d bcd=%0d/%0d required 0 0/0", count, bcd_tens, bcd_units);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || alarm !== 1'b0 || err_over !== 1'b0 || err_under !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b alarm=%b eo=%b eu=%b required 1 0 0 0 0",
               empty, full, alarm, err_over, err_under);
    end
  endtask

  task automatic test_up_down();
    logic [6:0] exp_seq [4];
    exp_seq[0] = 7'd1; exp_seq[1] = 7'd2; exp_seq[2] = 7'd3; exp_seq[3] = 7'd2;
    for (int i = 0; i < 4; i++) begin
      pulse(i < 3, i == 3, 1'b0);
      checks++;
      if (count !== exp_seq[i] || bcd_tens !== 4'd0 || bcd_units !== exp_seq[i][3:0]) begin
        errors++;
        $display("FAIL up_down_step%0d: count=%0d bcd=%0d/%0d required %0d 0/%0d",
                 i, count, bcd_tens, bcd_units, exp_seq[i], exp_seq[i]);
      end
    end
    checks++;
    if (empty !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL up_down_flags: empty=%b full=%b required 0 0", empty, full);
    end
  endtask

  task automatic test_bcd_carry();
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      checks++;
      if (count !== 7'(i) || bcd_tens !== 4'(i / 10) || bcd_units !== 4'(i % 10)) begin
        errors++;
        $display("FAIL bcd_up%0d: count=%0d bcd=%0d/%0d required %0d %0d/%0d",
                 i, count, bcd_tens, bcd_units, i, i / 10, i % 10);
      end
    end
    pulse(1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== 7'd9 || bcd_tens !== 4'd0 || bcd_units !== 4'd9) begin
      errors++;
      $display("FAIL bcd_borrow: count=%0d bcd=%0d/%0d required 9 0/9", count, bcd_tens, bcd_units);
    end
  endtask

  task automatic test_saturation_full();
    pulse(1'b0, 1'b0, 1'b1);
    repeat (24) pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 7'd24 || full !== 1'b0) begin
      errors++;
      $display("FAIL near_full: count=%0d full=%b required 24 0", count, full);
    end
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 7'd25 || full !== 1'b1 || bcd_tens !== 4'd2 || bcd_units !== 4'd5 ||
        err_over !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL at_full: count=%0d full=%b bcd=%0d/%0d eo=%b alarm=%b required 25 1 2/5 0 0",
               count, full, bcd_tens, bcd_units, err_over, alarm);
    end
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 7'd25 || err_over !== 1'b1 || alarm !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow: count=%0d eo=%b alarm=%b full=%b required 25 1 1 1",
               count, err_over, alarm, full);
    end
    @(negedge clk);
    checks++;
    if (err_over !== 1'b0 || alarm !== 1'b1 || count !== 7'd25) begin
      errors++;
      $display("FAIL overflow_after: eo=%b alarm=%b count=%0d required 0 1 25", err_over, alarm, count);
    end
    pulse(1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== 7'd24 || full !== 1'b0 || bcd_tens !== 4'd2 || bcd_units !== 4'd4 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL leave_full: count=%0d full=%b bcd=%0d/%0d alarm=%b required 24 0 2/4 1",
               count, full, bcd_tens, bcd_units, alarm);
    end
  endtask

  task automatic test_underflow_clr();
    pulse(1'b0, 1'b0, 1'b1);
    checks++;
    if (count !== 7'd0 || alarm !== 1'b0 || empty !== 1'b1 || bcd_tens !== 4'd0 || bcd_units !== 4'd0) begin
      errors++;
      $display("FAIL clr_state: count=%0d alarm=%b empty=%b bcd=%0d/%0d required 0 0 1 0/0",
               count, alarm, empty, bcd_tens, bcd_units);
    end
    pulse(1'b0, 1'b1, 1'b0);
    checks++;
    if (err_under !== 1'b1 || alarm !== 1'b1 || count !== 7'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow: eu=%b alarm=%b count=%0d empty=%b required 1 1 0 1",
               err_under, alarm, count, empty);
    end
    @(negedge clk);
    checks++;
    if (err_under !== 1'b0 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL underflow_after: eu=%b alarm=%b required 0 1", err_under, alarm);
    end
    pulse(1'b0, 1'b0, 1'b1);
    checks++;
    if (alarm !== 1'b0 || count !== 7'd0) begin
      errors++;
      $display("FAIL alarm_clr: alarm=%b count=%0d required 0 0", alarm, count);
    end
  endtask

  task automatic test_simultaneous_and_async_reset();
    pulse(1'b0, 1'b0, 1'b1);
    repeat (5) pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    checks++;
    if (count !== 7'd5 || err_over !== 1'b0 || err_under !== 1'b0 || alarm !== 1'b0 ||
        bcd_units !== 4'd5) begin
      errors++;
      $display("FAIL both_inputs: count=%0d eo=%b eu=%b alarm=%b units=%0d required 5 0 0 0 5",
               count, err_over, err_under, alarm, bcd_units);
    end
    // Posedge is 5 units after this negedge; reset lands mid-cycle
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (count !== 7'd0 || bcd_units !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d units=%0d empty=%b full=%b alarm=%b required 0 0 1 0 0",
               count, bcd_units, empty, full, alarm);
    end
    @(negedge clk);
    x0 = 1'b1;
    @(negedge clk);
    x0 = 1'b0;
    reset = 1'b0;
    checks++;
    if (count !== 7'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_overrides: count=%0d empty=%b required 0 1", count, empty);
    end
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 7'd1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_inc: count=%0d empty=%b required 1 0", count, empty);
    end
  endtask

  initial begin
    test_reset();
    test_up_down();
    test_bcd_carry();
    test_saturation_full();
    test_underflow_clr();
    test_simultaneous_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
